// File: rtl/adc_thermometer_decoder.sv
`default_nettype none
// ============================================================================
// Module   : adc_thermometer_decoder
// Brief    : Flash-ADC thermometer (15b) to binary (4b) decoder with a
//            two-flop synchroniser, optional bubble correction
//            (ADC_BUBBLE_CORRECT_EN), and a valid/ready output that reports
//            overrun and code errors.
// Revision : 1.0 - initial release
// ============================================================================
module adc_thermometer_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] comp_in,
    input  logic        sample_en,
    output logic [3:0]  out_data,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int c_nbits = 15;

    logic [14:0] r_sync1;
    logic [14:0] r_sync2;
    logic [14:0] r_a_code;
    logic        r_a_vld;
    logic [14:0] w_corr;
    logic [3:0]  w_count;
    logic        w_err;
    logic        w_load;
    logic        w_drop;
    logic [3:0]  r_out_data;
    logic        r_out_err;
    logic        r_out_valid;
    logic        r_overrun;

`ifdef ADC_BUBBLE_CORRECT_EN
    // Padded so bit -1 reads as 1 and bit 15 reads as 0.
    logic [16:0] w_ext;
    assign w_ext = {1'b0, r_sync2, 1'b1};

    for (genvar gi = 0; gi < c_nbits; gi++) begin : g_maj
        assign w_corr[gi] = (w_ext[gi]   & w_ext[gi+1]) |
                            (w_ext[gi]   & w_ext[gi+2]) |
                            (w_ext[gi+1] & w_ext[gi+2]);
    end
`else
    assign w_corr = r_sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_a_code <= '0;
            r_a_vld  <= 1'b0;
        end else begin
            r_sync1 <= comp_in;
            r_sync2 <= r_sync1;
            r_a_vld <= sample_en;
            if (sample_en) begin
                r_a_code <= w_corr;
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < c_nbits; i++) begin
            w_count = w_count + {3'b000, r_a_code[i]};
        end
    end

    // Any 0 sitting below a 1 breaks the thermometer property.
    assign w_err  = |(~r_a_code[13:0] & r_a_code[14:1]);

    assign w_load = r_a_vld & (~r_out_valid | out_ready);
    assign w_drop = r_a_vld & r_out_valid & ~out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_data  <= w_count;
                r_out_err   <= w_err;
                r_out_valid <= 1'b1;
            end else if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
